// File: rtl/io_uart_tx_mmio_if.sv
// io_uart_tx_mmio_if: CPU store-to-I/O bus (word address, data, byte enables).
interface io_uart_tx_mmio_if;
    logic [11:2] st_adr_io;
    logic [31:0] st_data_io;
    logic [3:0]  st_we_io;
    modport master (output st_adr_io, st_data_io, st_we_io);
    modport slave  (input  st_adr_io, st_data_io, st_we_io);
endinterface

// File: rtl/io_uart_tx_mmio.sv
// io_uart_tx_mmio: MMIO LED register plus TX FIFO feeding an 8N1 UART serialiser.
// Define IO_UART_TX_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise a single holding register is used.
module io_uart_tx_mmio #(
    parameter int CLK_DIV    = 434,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    io_uart_tx_mmio_if.slave        st,
    input  logic                    ovf_clr,
    output logic                    uart_tx,
    output logic [2:0]              led,
    output logic                    tx_busy,
    output logic                    tx_full,
    output logic                    tx_overflow
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] BAUD_LOAD = CW'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic [2:0]    led_q, led_d;
    logic          ovf_q, ovf_d;
    logic          wr_tx, wr_led, push, pop, empty, baud_last;
    logic [7:0]    rd_data;
    logic          unused_bits;

    assign wr_tx       = st.st_we_io[0] && st.st_adr_io == 10'h3FE;
    assign wr_led      = st.st_we_io[0] && st.st_adr_io == 10'h3FC;
    assign push        = wr_tx && !tx_full;
    assign unused_bits = ^{st.st_data_io[31:8], st.st_we_io[3:1]};

`ifdef IO_UART_TX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [AW:0]   fill_q, fill_d;

    always_comb begin
        wp_d   = push ? wp_q + 1'b1 : wp_q;
        rp_d   = pop ? rp_q + 1'b1 : rp_q;
        fill_d = fill_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end

    assign empty   = fill_q == '0;
    assign tx_full = fill_q == (AW+1)'(FIFO_DEPTH);
    assign rd_data = mem[rp_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q   <= '0;
            rp_q   <= '0;
            fill_q <= '0;
        end else begin
            wp_q   <= wp_d;
            rp_q   <= rp_d;
            fill_q <= fill_d;
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem[wp_q] <= st.st_data_io[7:0];
    end
`else
    logic [7:0] hold_q, hold_d;
    logic       hold_vld_q, hold_vld_d;

    always_comb begin
        hold_d     = push ? st.st_data_io[7:0] : hold_q;
        hold_vld_d = push || (hold_vld_q && !pop);
    end

    assign empty   = !hold_vld_q;
    assign tx_full = hold_vld_q;
    assign rd_data = hold_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
        end else begin
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
        end
    end
`endif

    assign baud_last = baud_q == '0;
    // A pop at the end of a stop bit chains the next frame with no idle gap.
    assign pop       = !empty && (state_q == IDLE || (state_q == STOP && baud_last));

    always_comb begin
        state_d = state_q;
        baud_d  = baud_last ? BAUD_LOAD : baud_q - 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        unique case (state_q)
            IDLE: begin
                baud_d = BAUD_LOAD;
                if (pop) begin
                    state_d = START;
                    shift_d = rd_data;
                end
            end
            START: begin
                if (baud_last) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                end
            end
            DATA: begin
                if (baud_last) begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (baud_last) begin
                    state_d = pop ? START : IDLE;
                    if (pop) shift_d = rd_data;
                end
            end
        endcase
        tx_d  = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
        led_d = wr_led ? st.st_data_io[2:0] : led_q;
        ovf_d = (wr_tx && tx_full) ? 1'b1 : ovf_clr ? 1'b0 : ovf_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= BAUD_LOAD;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            led_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            led_q   <= led_d;
            ovf_q   <= ovf_d;
        end
    end

    assign uart_tx     = tx_q;
    assign led         = led_q;
    assign tx_overflow = ovf_q;
    assign tx_busy     = !empty || state_q != IDLE;
endmodule

// File: tb/tb_io_uart_tx_mmio.sv
// tb_io_uart_tx_mmio: directed vectors for io_uart_tx_mmio with CLK_DIV=4, FIFO_DEPTH=4.
// Expectations adapt to IO_UART_TX_FIFO_EN (FIFO) versus the default single holding register.
module tb_io_uart_tx_mmio;
    localparam int CLK = 4;
    localparam int FRAME = 10 * CLK;
`ifdef IO_UART_TX_FIFO_EN
    localparam int N_PUSH = 6;
    localparam int N_OK = 5;
    localparam int FULL_AT = 4;
    localparam logic FULL_AFTER_ONE = 1'b0;
`else
    localparam int N_PUSH = 2;
    localparam int N_OK = 1;
    localparam int FULL_AT = 0;
    localparam logic FULL_AFTER_ONE = 1'b1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ovf_clr = 1'b0;
    logic uart_tx, tx_busy, tx_full, tx_overflow;
    logic [2:0] led;
    int n_chk = 0;
    int n_fail = 0;
    logic [199:0] cap;
    logic [7:0] exp_q[$];

    io_uart_tx_mmio_if bus ();

    io_uart_tx_mmio #(.CLK_DIV(CLK), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .st(bus), .ovf_clr(ovf_clr), .uart_tx(uart_tx),
        .led(led), .tx_busy(tx_busy), .tx_full(tx_full), .tx_overflow(tx_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:2] adr;
        logic [31:0] data;
        logic [3:0]  we;
        logic [2:0]  led;
    } vec_t;
    vec_t vt[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [11:2] adr, input logic [31:0] data, input logic [3:0] we);
        bus.st_adr_io = adr;
        bus.st_data_io = data;
        bus.st_we_io = we;
    endtask

    task automatic store(input logic [11:2] adr, input logic [31:0] data, input logic [3:0] we);
        drive(adr, data, we);
        tick();
        drive('0, '0, '0);
    endtask

    task automatic capture(input int n);
        cap = '1;
        for (int k = 0; k < n; k++) begin
            cap[k] = uart_tx;
            tick();
        end
    endtask

    task automatic check_line(input string name);
        logic [199:0] e;
        e = '1;
        foreach (exp_q[i])
            for (int k = 0; k < FRAME; k++) begin
                int bt;
                bt = k / CLK;
                e[i*FRAME+k] = bt == 0 ? 1'b0 : bt == 9 ? 1'b1 : exp_q[i][bt-1];
            end
        check(name, cap, e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{10'h3FC, 32'hFFFF_FFF5, 4'b0001, 3'b101};
        vt[1] = '{10'h3FC, 32'h0000_0002, 4'b1110, 3'b101};
        vt[2] = '{10'h3FC, 32'h0000_0002, 4'b0001, 3'b010};
        vt[3] = '{10'h3FD, 32'h0000_0007, 4'b0001, 3'b010};
        vt[4] = '{10'h3FE, 32'h0000_00AA, 4'b1110, 3'b010};
        vt[5] = '{10'h3FC, 32'h0000_000F, 4'b1111, 3'b111};
        vt[6] = '{10'h000, 32'h0000_0000, 4'b0001, 3'b111};
        vt[7] = '{10'h3FC, 32'h0000_0000, 4'b0000, 3'b111};
        vt[8] = '{10'h3FC, 32'h1234_5678, 4'b0001, 3'b000};
        drive('0, '0, '0);
        #1 rst = 1'b1;
        #2;
        check("rst_uart_tx", 200'(uart_tx), 200'(1'b1));
        check("rst_led", 200'(led), 200'(3'b000));
        check("rst_busy", 200'(tx_busy), 200'(1'b0));
        check("rst_full", 200'(tx_full), 200'(1'b0));
        check("rst_ovf", 200'(tx_overflow), 200'(1'b0));
        tick();
        tick();
        rst = 1'b0;
        tick();

        foreach (vt[i]) begin
            store(vt[i].adr, vt[i].data, vt[i].we);
            check($sformatf("vec%0d_led", i), 200'(led), 200'(vt[i].led));
            check($sformatf("vec%0d_busy", i), 200'(tx_busy), 200'(1'b0));
            check($sformatf("vec%0d_line", i), 200'(uart_tx), 200'(1'b1));
        end

        store(10'h3FE, 32'h0000_0055, 4'b0001);
        check("single_busy_after_push", 200'(tx_busy), 200'(1'b1));
        check("single_line_latency", 200'(uart_tx), 200'(1'b1));
        check("single_full", 200'(tx_full), 200'(FULL_AFTER_ONE));
        tick();
        capture(FRAME);
        exp_q = '{8'h55};
        check_line("single_frame");
        check("single_busy_end", 200'(tx_busy), 200'(1'b0));
        tick();

        fork
            begin
                store(10'h3FE, 32'h0000_00A5, 4'b0001);
`ifndef IO_UART_TX_FIFO_EN
                tick();
`endif
                store(10'h3FE, 32'h0000_003C, 4'b0001);
            end
            begin
                tick();
                tick();
                capture(2 * FRAME);
            end
        join
        exp_q = '{8'hA5, 8'h3C};
        check_line("b2b_frames");
        check("b2b_busy_end", 200'(tx_busy), 200'(1'b0));
        check("b2b_no_ovf", 200'(tx_overflow), 200'(1'b0));
        tick();

        fork
            begin
                for (int i = 0; i < N_PUSH; i++) begin
                    drive(10'h3FE, 32'(8'h11 * (i + 1)), 4'b0001);
                    tick();
                    if (i == FULL_AT) check("ovf_full", 200'(tx_full), 200'(1'b1));
                    if (i == N_PUSH - 2) check("ovf_not_yet", 200'(tx_overflow), 200'(1'b0));
                end
                drive('0, '0, '0);
                check("ovf_set", 200'(tx_overflow), 200'(1'b1));
            end
            begin
                tick();
                tick();
                capture(N_OK * FRAME);
            end
        join
        exp_q = '{};
        for (int i = 0; i < N_OK; i++) exp_q.push_back(8'(8'h11 * (i + 1)));
        check_line("ovf_frames");
        check("ovf_busy_end", 200'(tx_busy), 200'(1'b0));
        check("ovf_sticky", 200'(tx_overflow), 200'(1'b1));
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_cleared", 200'(tx_overflow), 200'(1'b0));

        store(10'h3FC, 32'h0000_0006, 4'b0001);
        check("mid_led_set", 200'(led), 200'(3'b110));
        store(10'h3FE, 32'h0000_0096, 4'b0001);
`ifdef IO_UART_TX_FIFO_EN
        store(10'h3FE, 32'h0000_0077, 4'b0001);
`else
        tick();
`endif
        for (int i = 0; i < 17; i++) tick();
        check("mid_bit3_low", 200'(uart_tx), 200'(1'b0));
        rst = 1'b1;
        #1;
        check("mid_rst_line", 200'(uart_tx), 200'(1'b1));
        check("mid_rst_busy", 200'(tx_busy), 200'(1'b0));
        check("mid_rst_led", 200'(led), 200'(3'b000));
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_idle", 200'(tx_busy), 200'(1'b0));
        store(10'h3FE, 32'h0000_005A, 4'b0001);
        tick();
        capture(FRAME);
        exp_q = '{8'h5A};
        check_line("post_rst_frame");
        check("post_rst_busy_end", 200'(tx_busy), 200'(1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
